imem_loadable: RTL

Parametrised instruction memory for the single-cycle microprocessor. It replaces the fixed reset-time program image with a byte-serial load port and a load/clear state machine. The CPU fetch port stays combinational with byte addressing. While a program is being loaded, the fetch port returns the HALT word, so the core idles safely.

---
 rtl/imem_loadable.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/imem_loadable.sv
// imem_loadable: byte-serial loadable instruction memory with a
// combinational, byte-addressed CPU fetch port.
//
// Optional feature: define IMEM_CHECKSUM_EN to build the LD_SUM
// modulo-256 byte checksum; otherwise LD_SUM is tied to 8'h00.
//
// Ports:
//   CLK      clock, all state updates on the rising edge
//   RESET    asynchronous active-high reset
//   ADDR     CPU fetch byte address
//   Q        fetched instruction (HALT_WORD while loading/out of range)
//   LD_START begin a program load (honoured in IDLE and DONE only)
//   LD_VALID LD_BYTE is valid
//   LD_READY byte accepted this cycle (high throughout LOAD)
//   LD_BYTE  program byte, MS byte of each word first
//   LD_LAST  marks the final program byte
//   LOADING  high in LOAD and CLEAR
//   LD_DONE  load and clear complete
//   LD_ERR   program exceeded DEPTH words
//   LD_SUM   checksum of accepted bytes
`default_nettype none

module imem_loadable #(
  parameter int                 DATA_W    = 16,
  parameter int                 ADDR_W    = 8,
  parameter int                 DEPTH     = 128,
  parameter logic [DATA_W-1:0]  HALT_WORD = DATA_W'(16'h0001)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Q,
  input  logic              LD_START,
  input  logic              LD_VALID,
  output logic              LD_READY,
  input  logic [7:0]        LD_BYTE,
  input  logic              LD_LAST,
  output logic              LOADING,
  output logic              LD_DONE,
  output logic              LD_ERR,
  output logic [7:0]        LD_SUM
);

  localparam int NB  = DATA_W / 8;
  localparam int B   = $clog2(NB);
  localparam int IW  = ADDR_W - B;
  localparam int IWP = IW + 1;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WPW = $clog2(DEPTH + 1);
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;

  localparam logic [WPW-1:0] WP_MAX  = WPW'(DEPTH);
  localparam logic [BCW-1:0] BC_MAX  = BCW'(NB - 1);
  localparam logic [IW:0]    IDX_LIM = IWP'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_DONE
  } state_t;

  state_t            st_q, st_d;
  logic [WPW-1:0]    wp_q, wp_d;
  logic [BCW-1:0]    bc_q, bc_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              we;
  logic [AW-1:0]     wa;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] asm_sh;
  logic              full;
  logic              go;
  logic              acc;
  int                pad;

  logic [IW-1:0]     idx;
  logic              in_rng;

  assign full   = (wp_q == WP_MAX);
  assign go     = LD_START & ((st_q == S_IDLE) | (st_q == S_DONE));
  assign acc    = LD_VALID & (st_q == S_LOAD);
  assign asm_sh = (asm_q << 8) | DATA_W'(LD_BYTE);

  // A word closed early by LD_LAST is left-justified, so the
  // bytes that never arrived read back as zero.
  assign pad = 8 * (NB - 1 - int'(bc_q));

  always_comb begin
    st_d  = st_q;
    wp_d  = wp_q;
    bc_d  = bc_q;
    asm_d = asm_q;
    err_d = err_q;
    we    = 1'b0;
    wa    = wp_q[AW-1:0];
    wd    = '0;
    unique case (st_q)
      S_IDLE, S_DONE: begin
        if (LD_START) begin
          st_d  = S_LOAD;
          wp_d  = '0;
          bc_d  = '0;
          asm_d = '0;
          err_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (LD_VALID) begin
          // Bytes past the end are dropped but flagged.
          if (full) begin
            err_d = 1'b1;
          end
          if ((bc_q == BC_MAX) || LD_LAST) begin
            bc_d  = '0;
            asm_d = '0;
            if (!full) begin
              we   = 1'b1;
              wd   = asm_sh << pad;
              wp_d = wp_q + 1'b1;
            end
          end else begin
            bc_d  = bc_q + 1'b1;
            asm_d = asm_sh;
          end
          if (LD_LAST) begin
            st_d = S_CLEAR;
          end
        end
      end
      S_CLEAR: begin
        if (full) begin
          st_d = S_DONE;
        end else begin
          we   = 1'b1;
          wd   = '0;
          wp_d = wp_q + 1'b1;
        end
      end
      default: begin
        st_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      st_q  <= S_IDLE;
      wp_q  <= '0;
      bc_q  <= '0;
      asm_q <= '0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      wp_q  <= wp_d;
      bc_q  <= bc_d;
      asm_q <= asm_d;
      err_q <= err_d;
    end
  end

  // Program storage is deliberately not reset: an image
  // survives RESET until the next load clears it.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

`ifdef IMEM_CHECKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sum_q <= 8'h00;
    end else if (go) begin
      sum_q <= 8'h00;
    end else if (acc) begin
      sum_q <= sum_q + LD_BYTE;
    end
  end

  assign LD_SUM = sum_q;
`else
  logic unused_go;
  logic unused_acc;

  assign unused_go  = go;
  assign unused_acc = acc;
  assign LD_SUM     = 8'h00;
`endif

  assign LD_READY = (st_q == S_LOAD);
  assign LOADING  = (st_q == S_LOAD) | (st_q == S_CLEAR);
  assign LD_DONE  = (st_q == S_DONE);
  assign LD_ERR   = err_q;

  // Fetch: byte address -> word index; the byte-lane bits
  // below B do not select anything.
  assign idx    = ADDR[ADDR_W-1:B];
  assign in_rng = ({1'b0, idx} < IDX_LIM);

  generate
    if (B > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^ADDR[B-1:0];
    end
  endgenerate

  assign Q = (LOADING || !in_rng) ? HALT_WORD
                                  : mem[idx[AW-1:0]];

endmodule

`default_nettype wire
